acc_pipe_ctrl: RTL and testbench

- Handshake and register-enable controller for the 3-neuron accelerator pipeline: layer-1 stage registers, then the output register.
- Tracks one valid bit per pipeline stage.
- Converts the upstream valid/ready and downstream ready_out/valid_out handshakes into per-stage load enables.
- Supports full throughput, bubble collapsing under back-pressure, and a synchronous flush.
- Sits beside the datapath and drives the enable inputs of every stage register.

---
 rtl/acc_pipe_ctrl.sv | 160 ++++++++++++++++
 tb/tb_acc_pipe_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/acc_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : acc_pipe_ctrl
// Brief    : Valid/ready stall-chain controller generating per-stage load
//            enables for the accelerator pipeline. Optional macro
//            ACC_PIPE_PERF_CNT_EN adds saturating accept/done/stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module acc_pipe_ctrl #(
    parameter int STAGES = 3,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              valid,
    output logic              ready,
    output logic              valid_out,
    input  logic              ready_out,
    input  logic              flush,
    output logic [STAGES-1:0] en,
    output logic              busy,
    output logic [CNT_W-1:0]  occupancy
`ifdef ACC_PIPE_PERF_CNT_EN
    ,
    output logic [15:0]       acc_count,
    output logic [15:0]       done_count,
    output logic [15:0]       stall_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [STAGES-1:0] r_v;
    logic [STAGES-1:0] w_v_nxt;
    logic [STAGES-1:0] w_move;
    logic [STAGES-1:0] w_up;
    logic [CNT_W-1:0]  r_occ;
    logic [CNT_W-1:0]  w_occ_nxt;
    logic              w_run_ok;
    logic              w_accept;

    assign w_run_ok = arst && (r_state != S_FLUSH);

    // A stage may advance if it is empty or anything downstream of it advances.
    always_comb begin : p_move
        logic w_chain;
        w_move  = '0;
        w_chain = ready_out;
        for (int i = STAGES - 1; i >= 0; i--) begin
            w_chain   = !r_v[i] || w_chain;
            w_move[i] = w_chain;
        end
    end

    always_comb begin : p_up
        w_up    = '0;
        w_up[0] = valid;
        for (int i = 1; i < STAGES; i++) begin
            w_up[i] = r_v[i-1];
        end
    end

    assign ready    = w_move[0] && w_run_ok;
    assign w_accept = valid && ready;
    assign en       = w_run_ok ? (w_move & w_up) : '0;

    always_comb begin : p_vnext
        w_v_nxt   = r_v;
        w_occ_nxt = '0;
        for (int i = 0; i < STAGES; i++) begin
            if (w_move[i]) begin
                w_v_nxt[i] = (i == 0) ? w_accept : w_up[i];
            end
        end
        // Flush overrides any load on the same edge.
        if (flush) begin
            w_v_nxt = '0;
        end
        for (int i = 0; i < STAGES; i++) begin
            w_occ_nxt = w_occ_nxt + CNT_W'(w_v_nxt[i]);
        end
    end

    always_comb begin : p_fsm_next
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (flush) begin
                    w_state_nxt = S_FLUSH;
                end else if (w_accept) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (flush) begin
                    w_state_nxt = S_FLUSH;
                end else if (w_v_nxt == '0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_FLUSH: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arst) begin
            r_state <= S_IDLE;
            r_v     <= '0;
            r_occ   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_v     <= w_v_nxt;
            r_occ   <= w_occ_nxt;
        end
    end

    assign valid_out = arst && r_v[STAGES-1];
    assign busy      = arst && (r_state != S_IDLE);
    assign occupancy = arst ? r_occ : '0;

`ifdef ACC_PIPE_PERF_CNT_EN
    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    logic [15:0] r_acc_cnt;
    logic [15:0] r_done_cnt;
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!arst) begin
            r_acc_cnt   <= '0;
            r_done_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_accept && (r_acc_cnt != c_CNT_MAX)) begin
                r_acc_cnt <= r_acc_cnt + 16'd1;
            end
            if (valid_out && ready_out && (r_done_cnt != c_CNT_MAX)) begin
                r_done_cnt <= r_done_cnt + 16'd1;
            end
            if (valid_out && !ready_out && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign acc_count   = r_acc_cnt;
    assign done_count  = r_done_cnt;
    assign stall_count = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_acc_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_acc_pipe_ctrl
// Brief    : Directed plus random stimulus for acc_pipe_ctrl, checked against
//            a slot-occupancy model of the pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module tb_acc_pipe_ctrl;

    localparam int c_STAGES = 3;
    localparam int c_CNT_W  = 4;
    localparam int c_IDLE   = 0;
    localparam int c_RUN    = 1;
    localparam int c_FLUSH  = 2;

    logic                clk = 1'b0;
    logic                arst = 1'b0;
    logic                valid = 1'b0;
    logic                ready_out = 1'b0;
    logic                flush = 1'b0;
    logic                ready;
    logic                valid_out;
    logic                busy;
    logic [c_STAGES-1:0] en;
    logic [c_CNT_W-1:0]  occupancy;
`ifdef ACC_PIPE_PERF_CNT_EN
    logic [15:0]         acc_count;
    logic [15:0]         done_count;
    logic [15:0]         stall_count;
    int                  m_acc   = 0;
    int                  m_done  = 0;
    int                  m_stall = 0;
`endif

    int n_checks  = 0;
    int n_errors  = 0;
    int n_accepts = 0;
    bit m_v [c_STAGES];
    int m_state = c_IDLE;

    always #5 clk = ~clk;

    acc_pipe_ctrl #(
        .STAGES (c_STAGES),
        .CNT_W  (c_CNT_W)
    ) u_dut (
        .clk        (clk),
        .arst       (arst),
        .valid      (valid),
        .ready      (ready),
        .valid_out  (valid_out),
        .ready_out  (ready_out),
        .flush      (flush),
        .en         (en),
        .busy       (busy),
        .occupancy  (occupancy)
`ifdef ACC_PIPE_PERF_CNT_EN
        ,
        .acc_count  (acc_count),
        .done_count (done_count),
        .stall_count(stall_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check outputs mid-cycle, then advance the model.
    task automatic cycle(input logic a, input logic v, input logic ro, input logic f);
        bit                  nv     [c_STAGES];
        bit                  landed [c_STAGES];
        logic [c_STAGES-1:0] exp_en;
        logic                exp_ready;
        logic                exp_vo;
        logic                acc;
        int                  occ;
        bit                  any;
        arst      = a;
        valid     = v;
        ready_out = ro;
        flush     = f;
        @(negedge clk);
        nv = m_v;
        for (int i = 0; i < c_STAGES; i++) landed[i] = 1'b0;
        if (nv[c_STAGES-1] && ro) nv[c_STAGES-1] = 1'b0;
        for (int i = c_STAGES - 2; i >= 0; i--) begin
            if (nv[i] && !nv[i+1]) begin
                nv[i+1]     = 1'b1;
                nv[i]       = 1'b0;
                landed[i+1] = 1'b1;
            end
        end
        exp_ready = a && (m_state != c_FLUSH) && !nv[0];
        acc       = exp_ready && v;
        if (acc) begin
            nv[0]     = 1'b1;
            landed[0] = 1'b1;
        end
        exp_en = '0;
        for (int i = 0; i < c_STAGES; i++)
            exp_en[i] = a && (m_state != c_FLUSH) && landed[i];
        exp_vo = a && m_v[c_STAGES-1];
        occ = 0;
        for (int i = 0; i < c_STAGES; i++) occ += int'(m_v[i]);

        chk("ready", 32'(ready), 32'(exp_ready));
        chk("valid_out", 32'(valid_out), 32'(exp_vo));
        chk("en", 32'(en), 32'(exp_en));
        chk("busy", 32'(busy), 32'(a && (m_state != c_IDLE)));
        chk("occupancy", 32'(occupancy), a ? 32'(occ) : 32'd0);
`ifdef ACC_PIPE_PERF_CNT_EN
        chk("acc_count", 32'(acc_count), 32'(m_acc));
        chk("done_count", 32'(done_count), 32'(m_done));
        chk("stall_count", 32'(stall_count), 32'(m_stall));
`endif
        if (ready && v) n_accepts++;

        @(posedge clk);
        if (!a) begin
            for (int i = 0; i < c_STAGES; i++) m_v[i] = 1'b0;
            m_state = c_IDLE;
`ifdef ACC_PIPE_PERF_CNT_EN
            m_acc = 0; m_done = 0; m_stall = 0;
`endif
        end else begin
`ifdef ACC_PIPE_PERF_CNT_EN
            if (acc && m_acc < 65535) m_acc++;
            if (exp_vo && ro && m_done < 65535) m_done++;
            if (exp_vo && !ro && m_stall < 65535) m_stall++;
`endif
            if (m_state == c_FLUSH) begin
                m_v     = nv;
                m_state = c_IDLE;
            end else if (f) begin
                for (int i = 0; i < c_STAGES; i++) m_v[i] = 1'b0;
                m_state = c_FLUSH;
            end else begin
                m_v = nv;
                any = 1'b0;
                for (int i = 0; i < c_STAGES; i++) any |= nv[i];
                m_state = any ? c_RUN : c_IDLE;
            end
        end
        #1;
    endtask

    initial begin
        int snap;
        for (int i = 0; i < c_STAGES; i++) m_v[i] = 1'b0;

        // Reset, then a full-throughput stream and drain.
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) cycle(1'b1, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 1'b1, 1'b0);

        // Back-pressure fill, then same-cycle drain and accept.
        snap = n_accepts;
        for (int k = 0; k < 5; k++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        chk("fill_accepts", 32'(n_accepts - snap), 32'd3);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 1'b1, 1'b0);

        // Bubble collapse under back-pressure.
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 1'b1, 1'b0);

        // Flush a full pipe, with valid held high through the request cycle.
        for (int k = 0; k < 4; k++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);

        // Reset with two samples in flight; nothing stale may emerge.
        for (int k = 0; k < 2; k++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, 1'b1, 1'b0);

        // Accept/stall/drain mix for the counters.
        for (int k = 0; k < 10; k++) cycle(1'b1, 1'b1, k < 6 || k > 8, 1'b0);
        for (int k = 0; k < 6; k++) cycle(1'b1, 1'b0, 1'b1, 1'b0);

        // Random traffic with occasional flush and reset.
        for (int k = 0; k < 500; k++) begin
            cycle($urandom_range(0, 49) != 0,
                  $urandom_range(0, 9) < 7,
                  $urandom_range(0, 9) < 6,
                  $urandom_range(0, 29) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
